// File: rtl/fpga_cfg_pkg.sv
// Shared widths, FSM encoding and the serial CRC-8 step for the config loader.
package fpga_cfg_pkg;

  localparam int unsigned IO_W    = 20;
  localparam int unsigned CB_W    = 300;
  localparam int unsigned CBLR_W  = 120;
  localparam int unsigned SEL_W   = 9;
  localparam int unsigned BLE_W   = 144;
  localparam int unsigned SB_W    = 240;
  localparam int unsigned TOTAL_W = IO_W + CB_W + CBLR_W + SEL_W + BLE_W + SB_W;

  // LSB offsets of each slice inside the packed image (iostream at bit 0)
  localparam int unsigned CB_LSB   = IO_W;
  localparam int unsigned CBLR_LSB = CB_LSB + CB_W;
  localparam int unsigned SEL_LSB  = CBLR_LSB + CBLR_W;
  localparam int unsigned BLE_LSB  = SEL_LSB + SEL_W;
  localparam int unsigned SB_LSB   = BLE_LSB + BLE_W;

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned BCNT_W = 3;
  localparam logic [7:0]  CRC_POLY = 8'h07;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CRC, S_CHECK, S_COMMIT, S_DONE, S_ERROR
  } state_e;

  // One MSB-first CRC-8 step: init 0, no reflection, no final XOR
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/fpga_config_loader_if.sv
// Serial config stream handshake plus loader status flags.
interface fpga_config_loader_if;

  logic cfg_start;
  logic cfg_din;
  logic cfg_valid;
  logic cfg_ready;
  logic cfg_busy;
  logic cfg_done;
  logic cfg_error;

  modport master (
    output cfg_start, cfg_din, cfg_valid,
    input  cfg_ready, cfg_busy, cfg_done, cfg_error
  );

  modport slave (
    input  cfg_start, cfg_din, cfg_valid,
    output cfg_ready, cfg_busy, cfg_done, cfg_error
  );

endinterface

// File: rtl/cfg_crc8_serial.sv
// Bit-serial CRC-8 accumulator with synchronous clear.
module cfg_crc8_serial
  import fpga_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       enable_i,
  input  logic       din_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;

  // Next CRC: clear has priority over a shift step
  always_comb begin
    crc_d = crc_q;
    if (clear_i) begin
      crc_d = 8'h00;
    end else if (enable_i) begin
      crc_d = crc8_step(crc_q, din_i);
    end
  end

  // CRC register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/fpga_config_loader.sv
// Serial config loader: shadow-shifts an image, checks CRC-8, commits to the active buses only on a match.
module fpga_config_loader
  import fpga_cfg_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  fpga_config_loader_if.slave   cfg,
  output logic [IO_W-1:0]       iostream,
  output logic [CB_W-1:0]       cbstream1,
  output logic [CBLR_W-1:0]     cbstreamleft_or_right,
  output logic [SEL_W-1:0]      clb_mux_sel,
  output logic [BLE_W-1:0]      bitstream,
  output logic [SB_W-1:0]       sbstream
);

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [BCNT_W-1:0]    bcnt_q;
  logic [7:0]           crc_rx_q;
  logic [7:0]           crc_rx_d;
  logic [7:0]           crc_calc;
  logic [TOTAL_W-1:0]   shadow_q;
  logic [TOTAL_W-1:0]   shadow_d;
  logic [TOTAL_W-1:0]   active_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 error_q;
  logic                 start_take;
  logic                 accept;

  // A start is honoured everywhere except CHECK/COMMIT; a bit is dropped when it collides with start
  assign start_take = cfg.cfg_start && (state_q != S_CHECK) && (state_q != S_COMMIT);
  assign accept     = cfg.cfg_valid && ready_q && !cfg.cfg_start;

  assign shadow_d = {cfg.cfg_din, shadow_q[TOTAL_W-1:1]};
  assign crc_rx_d = {crc_rx_q[6:0], cfg.cfg_din};

  cfg_crc8_serial u_crc (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (start_take),
    .enable_i (accept && (state_q == S_LOAD)),
    .din_i    (cfg.cfg_din),
    .crc_o    (crc_calc)
  );

  // Load FSM with counters, shadow/active images and registered status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bcnt_q   <= '0;
      crc_rx_q <= 8'h00;
      shadow_q <= '0;
      active_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else if (start_take) begin
      state_q  <= S_LOAD;
      cnt_q    <= '0;
      bcnt_q   <= '0;
      crc_rx_q <= 8'h00;
      ready_q  <= 1'b1;
      busy_q   <= 1'b1;
      error_q  <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (accept) begin
            shadow_q <= shadow_d;
            if (cnt_q == CNT_W'(TOTAL_W - 1)) begin
              state_q <= S_CRC;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        S_CRC: begin
          if (accept) begin
            crc_rx_q <= crc_rx_d;
            bcnt_q   <= bcnt_q + BCNT_W'(1);
            if (bcnt_q == BCNT_W'(7)) begin
              state_q <= S_CHECK;
              ready_q <= 1'b0;
            end
          end
        end
        S_CHECK: begin
          if (crc_rx_q == crc_calc) begin
            state_q <= S_COMMIT;
          end else begin
            state_q <= S_ERROR;
            error_q <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        S_COMMIT: begin
          active_q <= shadow_q;
          state_q  <= S_DONE;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_busy  = busy_q;
  assign cfg.cfg_done  = done_q;
  assign cfg.cfg_error = error_q;

  assign iostream              = active_q[IO_W-1:0];
  assign cbstream1             = active_q[CB_LSB +: CB_W];
  assign cbstreamleft_or_right = active_q[CBLR_LSB +: CBLR_W];
  assign clb_mux_sel           = active_q[SEL_LSB +: SEL_W];
  assign bitstream             = active_q[BLE_LSB +: BLE_W];
  assign sbstream              = active_q[SB_LSB +: SB_W];

endmodule
